// File: rtl/backprop_cost.sv
// backprop_cost: two-stage pipelined saturated half-sum-of-squared-errors cost
module backprop_cost #(
  parameter int data_size = 4,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [data_size*size-1:0] y_stream,
  input  logic [data_size*size-1:0] label_stream,
  output logic [data_size-1:0]      cost
);
  localparam int DW2 = 2 * data_size;
  localparam int SW  = DW2 + $clog2(size + 1);
  logic [data_size-1:0] w_y    [size];
  logic [data_size-1:0] w_l    [size];
  logic [data_size-1:0] w_d    [size];
  logic [DW2-1:0]       w_sq   [size];
  logic [DW2-1:0]       r_sq   [size];
  logic [SW-1:0]        w_sum;
  logic [SW-1:0]        w_half;
  logic [data_size-1:0] w_sat;
  logic [data_size-1:0] r_cost;
  for (genvar g = 0; g < size; g++) begin : g_elem
    assign w_y[g]  = y_stream[data_size*g +: data_size];
    assign w_l[g]  = label_stream[data_size*g +: data_size];
    assign w_d[g]  = (w_y[g] >= w_l[g]) ? w_y[g] - w_l[g] : w_l[g] - w_y[g];
    assign w_sq[g] = DW2'(w_d[g]) * DW2'(w_d[g]);
  end
  // Stage 1: latch exact per-element squared differences
  always_ff @(posedge clk) begin
    for (int i = 0; i < size; i++)
      r_sq[i] <= rst ? '0 : w_sq[i];
  end
  // Sum squares in a width that can hold size full-scale terms without overflow
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < size; i++)
      w_sum = w_sum + SW'(r_sq[i]);
  end
  assign w_half = w_sum >> 1;
  assign w_sat  = (w_half > SW'({data_size{1'b1}})) ? '1 : w_half[data_size-1:0];
  // Stage 2: halved and saturated cost drives the output directly
  always_ff @(posedge clk) begin
    r_cost <= rst ? '0 : w_sat;
  end
  assign cost = r_cost;
endmodule

// File: tb/tb_backprop_cost.sv
// tb_backprop_cost: directed self-checking bench for backprop_cost
module tb_backprop_cost;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] y_stream = '0;
  logic [11:0] label_stream = '0;
  logic [3:0]  cost;
  int total = 0;
  int bad = 0;

  backprop_cost #(.data_size(4), .size(3)) dut (
    .clk(clk), .rst(rst), .y_stream(y_stream), .label_stream(label_stream), .cost(cost)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [11:0] y, input logic [11:0] l);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      int a, b, d;
      a = int'(y[4*i +: 4]);
      b = int'(l[4*i +: 4]);
      d = (a > b) ? a - b : b - a;
      s += d * d;
    end
    s = s / 2;
    return (s > 15) ? 4'hF : 4'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [11:0] y, input logic [11:0] l);
    y_stream = y;
    label_stream = l;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    y_stream = 12'hFFF;
    label_stream = 12'h000;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (cost !== 4'h0) begin bad++; $display("FAIL reset_hold%0d got=%h exp=0", i, cost); end
    end
    rst = 1'b0;
    step();
    total++;
    if (cost !== 4'h0) begin bad++; $display("FAIL reset_gap got=%h exp=0", cost); end
    step();
    total++;
    if (cost !== 4'hF) begin bad++; $display("FAIL reset_release got=%h exp=F", cost); end
  endtask

  task automatic test_match();
    apply(12'h5A3, 12'h5A3);
    total++;
    if (cost !== 4'h0) begin bad++; $display("FAIL exact_match got=%h exp=0", cost); end
  endtask

  task automatic test_rounding();
    apply(12'h123, 12'h221);
    total++;
    if (cost !== 4'h2) begin bad++; $display("FAIL round_s5 got=%h exp=2", cost); end
    apply(12'h221, 12'h123);
    total++;
    if (cost !== 4'h2) begin bad++; $display("FAIL round_swap got=%h exp=2", cost); end
    apply(12'h003, 12'h000);
    total++;
    if (cost !== 4'h4) begin bad++; $display("FAIL round_floor got=%h exp=4", cost); end
    apply(12'h000, 12'h300);
    total++;
    if (cost !== 4'h4) begin bad++; $display("FAIL round_elem2_under got=%h exp=4", cost); end
  endtask

  task automatic test_saturation();
    apply(12'hFFF, 12'h000);
    total++;
    if (cost !== 4'hF) begin bad++; $display("FAIL sat_full got=%h exp=F", cost); end
    apply(12'h006, 12'h000);
    total++;
    if (cost !== 4'hF) begin bad++; $display("FAIL sat_h18 got=%h exp=F", cost); end
    apply(12'h005, 12'h000);
    total++;
    if (cost !== 4'hC) begin bad++; $display("FAIL sat_h12 got=%h exp=C", cost); end
    apply(12'h000, 12'h0F0);
    total++;
    if (cost !== 4'hF) begin bad++; $display("FAIL sat_under got=%h exp=F", cost); end
    apply(12'h140, 12'h000);
    total++;
    if (cost !== 4'h8) begin bad++; $display("FAIL sat_h8 got=%h exp=8", cost); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ys [10];
    logic [11:0] ls [10];
    for (int k = 0; k < 10; k++) begin
      ys[k] = 12'(k * 291 + 17);
      ls[k] = 12'(k * 1234 + 99);
    end
    ys[3] = 12'h000; ls[3] = 12'h000;
    ys[6] = 12'h111; ls[6] = 12'h000;
    for (int k = 0; k <= 10; k++) begin
      y_stream = ys[(k < 10) ? k : 9];
      label_stream = ls[(k < 10) ? k : 9];
      step();
      if (k >= 1) begin
        total++;
        if (cost !== model(ys[k-1], ls[k-1])) begin
          bad++;
          $display("FAIL pipe%0d got=%h exp=%h", k - 1, cost, model(ys[k-1], ls[k-1]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    y_stream = 12'h005;
    label_stream = 12'h000;
    step();
    rst = 1'b1;
    y_stream = 12'h003;
    step();
    total++;
    if (cost !== 4'h0) begin bad++; $display("FAIL midrst_edge got=%h exp=0", cost); end
    rst = 1'b0;
    step();
    total++;
    if (cost !== 4'h0) begin bad++; $display("FAIL midrst_gap got=%h exp=0", cost); end
    step();
    total++;
    if (cost !== 4'h4) begin bad++; $display("FAIL midrst_post got=%h exp=4", cost); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/backprop_cost.md
# backprop_cost

Computes the scalar training cost C = ½·Σ(yᵢ − labelᵢ)² over a vector of `size` unsigned outputs and their labels, presented as packed parallel buses. It is the cost stage of the neural-burning backpropagation datapath: the forward-pass output vector and the target vector come in, and one saturated cost word goes out to the training/monitor logic. The block is fully pipelined, accepts a new vector pair every clock, and needs no handshake.

## Interface
Parameters:
- `data_size`, default 4: width in bits of each vector element and of `cost`.
- `size`, default 3: number of elements per vector (≥1).

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `y_stream`  input  data_size*size  packed network outputs, unsigned.
- `label_stream`  input  data_size*size  packed target labels, unsigned.
- `cost`  output  data_size  registered, saturated cost, unsigned.

## Operation
- Packing: element i (i = 0..size−1) occupies bits [data_size*(i+1)−1 : data_size*i] of each stream. Element order does not affect the result.
- Per element:
  - Compute dᵢ = |yᵢ − labelᵢ|. The width is data_size bits, and no wrap is allowed: when y < label, the block subtracts label − y.
  - Compute sqᵢ = dᵢ². The width is 2*data_size bits, and the result is exact.
- Sum:
  - S = Σ sqᵢ, with width 2*data_size + ceil(log2(size+1)) bits. The sum never overflows.
- Halve:
  - H = S >> 1, a floor division by 2.
- Saturate:
  - cost = H if H ≤ 2^data_size − 1.
  - Otherwise cost = 2^data_size − 1, which is all ones.
- The block is purely arithmetic and has no state machine. The only state is the pipeline registers.
- Inputs are sampled every clock. There are no valid/ready signals, and every cycle's input pair produces a corresponding output.

## Timing
- Stage 1 register:
  - Captures sqᵢ for all i from the current `y_stream` and `label_stream` at rising edge N.
- Stage 2 register:
  - Captures the summed, halved and saturated value at edge N+1. This register drives `cost` directly.
- Latency is 2 rising edges. Inputs present before edge N appear on `cost` after edge N+1.
- Throughput is one vector pair per clock.
- Reset:
  - While `rst` = 1 at a rising edge, both stage registers clear to 0. `cost` reads 0 after that edge.
  - Reset outranks the data path. Any vector in flight when reset asserts is discarded.
  - After `rst` deasserts, the first input sampled at edge N reaches `cost` after edge N+1. `cost` remains 0 in between.
- Inputs that change mid-cycle have no effect until they are sampled at the next rising edge.
- Output is glitch-free because it comes straight from a register.

## Test plan
Defaults data_size=4, size=3. Stream values are given element 2..0.
- Reset: hold `rst`=1 for 2 edges with y={F,F,F} and label={0,0,0} → `cost`=0 throughout. Release `rst`; the same inputs give `cost`=F two edges later.
- Exact match: y={5,A,3}, label={5,A,3} → `cost`=0 after 2 edges.
- Rounding and symmetry:
  - y={1,2,3}, label={2,2,1}: diffs 1,0,2, S=5 → `cost`=2.
  - Swapping y and label → `cost`=2.
  - y={0,0,3}, label=0: S=9 → `cost`=4 (floor).
- Saturation: y={F,F,F}, label={0,0,0}: S=675, H=337 → `cost`=F. Also y={0,0,6}, label=0: H=18 → `cost`=F. And y={0,0,5}, label=0: H=12 → `cost`=C.
- Pipelining: apply a different pair on each of 10 consecutive edges → each `cost` matches the reference model for the pair sampled 2 edges earlier, with no dropped or duplicated results.
- Reset mid-stream: assert `rst` for one edge between two distinct vectors → `cost`=0 on the following edges until the first post-reset vector emerges 2 edges after it is sampled. The pre-reset vector never appears.
